// File: rtl/mem_copy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_pkg
// Description : Shared constants and FSM state encoding for the block-copy
//               engine and its address generator.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_copy_pkg;

    localparam int c_MEM_DEPTH = 32;
    localparam int c_LEN_W     = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/copy_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : copy_addr_gen
// Description : Byte index / remaining-count tracker for the copy engine.
//               Walks the index up (ascending) or down (descending) and
//               forms the current source and destination addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module copy_addr_gen
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_desc,
    input  logic [c_LEN_W-1:0] i_len,
    input  logic               i_step,
    input  logic [ADDR_W-1:0]  i_src,
    input  logic [ADDR_W-1:0]  i_dst,
    output logic [ADDR_W-1:0]  o_src_addr,
    output logic [ADDR_W-1:0]  o_dst_addr,
    output logic               o_last
);

    localparam logic [c_LEN_W-1:0] c_ONE = c_LEN_W'(1);

    logic [c_LEN_W-1:0] r_idx;
    logic [c_LEN_W-1:0] r_remain;
    logic               r_desc;

    // Load start index/count on entry, then step once per written byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx    <= '0;
            r_remain <= '0;
            r_desc   <= 1'b0;
        end else if (i_load) begin
            r_desc   <= i_desc;
            r_idx    <= i_desc ? (i_len - c_ONE) : '0;
            r_remain <= i_len;
        end else if (i_step) begin
            r_idx    <= r_desc ? (r_idx - c_ONE) : (r_idx + c_ONE);
            r_remain <= r_remain - c_ONE;
        end
    end

    assign o_src_addr = i_src + ADDR_W'(r_idx);
    assign o_dst_addr = i_dst + ADDR_W'(r_idx);
    // The byte being written now is the final one of the run
    assign o_last     = (r_remain == c_ONE);

endmodule
`default_nettype wire

// File: rtl/mem_block_copier.sv
`default_nettype none
// ============================================================================
// Module      : mem_block_copier
// Description : Memory-port initiator that copies a run of bytes from a
//               source to a destination address with memmove semantics,
//               one READ/WRITE cycle pair per byte.
//               Optional feature macro: COPY_CHECKSUM_EN adds a `checksum`
//               output (mod-2^DATA_W sum of all bytes read).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_block_copier
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = c_MEM_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  src_addr,
    input  logic [ADDR_W-1:0]  dst_addr,
    input  logic [c_LEN_W-1:0] length,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [DATA_W-1:0]  mem_write_data,
    output logic               mem_write,
    output logic               mem_read,
    input  logic [DATA_W-1:0]  mem_read_data
`ifdef COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]  checksum
`endif
);

    // One extra bit so end-address sums never wrap
    localparam int                c_SUM_W = ADDR_W + 1;
    localparam logic [c_SUM_W-1:0] c_DEPTH = c_SUM_W'(MEM_DEPTH);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_src;
    logic [ADDR_W-1:0]  r_dst;
    logic [c_LEN_W-1:0] r_len;
    logic [DATA_W-1:0]  r_hold;
    logic               r_err;

    logic [c_SUM_W-1:0] w_src_end;
    logic [c_SUM_W-1:0] w_dst_end;
    logic               w_reject;
    logic               w_desc;
    logic [ADDR_W-1:0]  w_src_cur;
    logic [ADDR_W-1:0]  w_dst_cur;
    logic               w_last;

    assign w_src_end = {1'b0, r_src} + c_SUM_W'(r_len);
    assign w_dst_end = {1'b0, r_dst} + c_SUM_W'(r_len);
    assign w_reject  = (w_src_end > c_DEPTH) || (w_dst_end > c_DEPTH);
    // Destination starts inside the source run: copy from the top down
    assign w_desc    = (r_dst > r_src) && ({1'b0, r_dst} < w_src_end);

    copy_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .i_load     (r_state == ST_CHECK),
        .i_desc     (w_desc),
        .i_len      (r_len),
        .i_step     (r_state == ST_WRITE),
        .i_src      (r_src),
        .i_dst      (r_dst),
        .o_src_addr (w_src_cur),
        .o_dst_addr (w_dst_cur),
        .o_last     (w_last)
    );

    // Control FSM: capture request, validate, alternate READ/WRITE, finish
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_hold  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_src   <= src_addr;
                        r_dst   <= dst_addr;
                        r_len   <= length;
                        r_err   <= 1'b0;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_reject) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_len == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_hold  <= mem_read_data;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_state <= w_last ? ST_DONE : ST_READ;
                end
                ST_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef COPY_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // Running sum of every byte read; cleared when a request is captured
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_checksum <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_checksum <= '0;
        end else if (r_state == ST_READ) begin
            r_checksum <= r_checksum + mem_read_data;
        end
    end

    assign checksum = r_checksum;
`endif

    // Strobes decode from registered state only
    assign busy           = (r_state == ST_READ) || (r_state == ST_WRITE);
    assign done           = (r_state == ST_DONE);
    assign err            = (r_state == ST_DONE) && r_err;
    assign mem_read       = (r_state == ST_READ);
    assign mem_write      = (r_state == ST_WRITE);
    assign mem_address    = (r_state == ST_READ)  ? w_src_cur :
                            (r_state == ST_WRITE) ? w_dst_cur : '0;
    assign mem_write_data = (r_state == ST_WRITE) ? r_hold : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_block_copier.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_block_copier
// Description : Directed self-checking bench for mem_block_copier with a
//               behavioural data memory (combinational read, clocked write).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_block_copier;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [5:0] length;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] mem_address;
    logic [7:0] mem_write_data;
    logic       mem_write;
    logic       mem_read;
    logic [7:0] mem_read_data;
`ifdef COPY_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    logic [7:0] mem [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    int          done_cyc;
    logic        err_seen;
    int          n_rd;
    int          n_wr;
    int          n_viol;
    logic [31:0] wr_hist;
    logic [7:0]  ck_seen;

    mem_block_copier dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
`ifdef COPY_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_read_data = mem[mem_address];

    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem4(input int a);
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    // Launch one request and observe each cycle until done (bounded)
    task automatic run_op(input logic [7:0] s, input logic [7:0] d,
                          input logic [5:0] l, input int poke_cyc);
        @(negedge clk);
        src_addr = s; dst_addr = d; length = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src_addr = 8'hA5; dst_addr = 8'h5A; length = 6'd1;
        done_cyc = -1; err_seen = 1'b0; n_rd = 0; n_wr = 0; n_viol = 0;
        wr_hist = '0; ck_seen = '0;
        for (int c = 1; c <= 200; c++) begin
            if (mem_read) n_rd++;
            if (mem_write) begin
                n_wr++;
                wr_hist = {wr_hist[23:0], mem_address};
            end
            if (mem_read && mem_write) n_viol++;
            if (!mem_write && mem_write_data != 8'd0) n_viol++;
            if (!mem_read && !mem_write && mem_address != 8'd0) n_viol++;
            if (busy != (mem_read || mem_write)) n_viol++;
            if (done) begin
                done_cyc = c;
                err_seen = err;
`ifdef COPY_CHECKSUM_EN
                ck_seen = checksum;
`endif
                break;
            end
            start = (c == poke_cyc);
            if (c == poke_cyc) begin
                src_addr = 8'd0; dst_addr = 8'd0; length = 6'd1;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int extra;
        reset = 1'b0; start = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        for (int i = 0; i < 16; i++) begin
            mem[i]      = 8'(i);
            mem[16 + i] = 8'(-i);
        end
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs",
              {12'd0, busy, done, err, mem_read, mem_write, mem_address, mem_write_data, 1'b0},
              32'd0);
`ifdef COPY_CHECKSUM_EN
        check("reset_checksum", {24'd0, checksum}, 32'd0);
`endif
        reset = 1'b1;

        // Plain ascending copy
        run_op(8'd0, 8'd20, 6'd4, 0);
        check("t1_done_cyc", done_cyc, 10);
        check("t1_err", {31'd0, err_seen}, 0);
        check("t1_rd_wr", {n_rd[15:0], n_wr[15:0]}, {16'd4, 16'd4});
        check("t1_strobe_rules", n_viol, 0);
        check("t1_wr_addrs", wr_hist, 32'h14151617);
        check("t1_mem", mem4(20), 32'h00010203);
`ifdef COPY_CHECKSUM_EN
        check("t1_checksum", {24'd0, ck_seen}, 32'd6);
`endif

        // Five-byte copy; sum 1+2+3+4+5
        run_op(8'd1, 8'd16, 6'd5, 0);
        check("t2_done_cyc", done_cyc, 12);
        check("t2_mem", {mem4(16), mem[20]}, {32'h01020304, 8'h05});
`ifdef COPY_CHECKSUM_EN
        check("t2_checksum", {24'd0, ck_seen}, 32'h0F);
        repeat (3) @(negedge clk);
        check("t2_checksum_hold", {24'd0, checksum}, 32'h0F);
`endif

        // Overlapping forward move runs top-down
        run_op(8'd2, 8'd4, 6'd4, 0);
        check("t3_done_cyc", done_cyc, 10);
        check("t3_wr_addrs", wr_hist, 32'h07060504);
        check("t3_mem", mem4(4), 32'h02030405);
        check("t3_strobe_rules", n_viol, 0);

        // Ends exactly at MEM_DEPTH: accepted
        run_op(8'd16, 8'd28, 6'd4, 0);
        check("t4_done_err", {done_cyc[15:0], 15'd0, err_seen}, {16'd10, 16'd0});
        check("t4_mem", mem4(28), 32'h01020304);

        // Source runs past MEM_DEPTH: rejected
        run_op(8'd30, 8'd0, 6'd4, 0);
        check("t5_done_cyc", done_cyc, 2);
        check("t5_err", {31'd0, err_seen}, 1);
        check("t5_no_strobes", n_rd + n_wr + n_viol, 0);
`ifdef COPY_CHECKSUM_EN
        check("t5_checksum", {24'd0, ck_seen}, 32'd0);
`endif

        // Destination runs past MEM_DEPTH: rejected
        run_op(8'd0, 8'd29, 6'd4, 0);
        check("t6_done_err", {done_cyc[15:0], 15'd0, err_seen}, {16'd2, 16'd1});
        check("t6_no_strobes", n_rd + n_wr + n_viol, 0);

        // Zero length
        run_op(8'd3, 8'd9, 6'd0, 0);
        check("t7_done_err", {done_cyc[15:0], 15'd0, err_seen}, {16'd2, 16'd0});
        check("t7_no_strobes", n_rd + n_wr + n_viol, 0);

        // Start pulsed while busy is ignored
        run_op(8'd8, 8'd12, 6'd4, 4);
        check("t8_done_cyc", done_cyc, 10);
        extra = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("t8_no_second_op", extra, 0);
        check("t8_mem", mem4(12), 32'h08090A0B);

        // Reset during WRITE of byte 2 of a 6-byte copy
        @(negedge clk);
        src_addr = 8'd0; dst_addr = 8'd24; length = 6'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 7; c++) @(negedge clk);
        check("t9_in_write", {31'd0, mem_write}, 1);
        reset = 1'b0;
        #1;
        check("t9_async_drop",
              {13'd0, busy, done, err, mem_read, mem_write, mem_address, mem_write_data},
              32'd0);
        @(negedge clk);
        reset = 1'b1;
        check("t9_mem", mem4(24), 32'h0001F6F5);

        // Clean transfer after the reset
        run_op(8'd5, 8'd26, 6'd2, 0);
        check("t10_done_cyc", done_cyc, 6);
        check("t10_mem", {16'd0, mem[26], mem[27]}, 32'h0304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_block_copier.md
# mem_block_copier

Block-transfer engine that acts as the initiator on the data-memory port: it copies a run of bytes from a source address to a destination address with read/write strobes matching the data memory's protocol. The memory reads combinationally and writes on the clock edge. The engine sits beside the microprocessor datapath and is muxed onto the data-memory port while busy. Overlapping regions are handled with memmove semantics.

## Interface
Parameters:
- `ADDR_W`, default 8: address width on the memory port.
- `DATA_W`, default 8: data width.
- `MEM_DEPTH`, default 32: number of valid memory words; range limit for transfers.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low.
- `start`, input, 1: request pulse, sampled only in IDLE.
- `src_addr`, input, ADDR_W: first source address.
- `dst_addr`, input, ADDR_W: first destination address.
- `length`, input, 6: byte count, 0..32.
- `busy`, output, 1: high in READ and WRITE states.
- `done`, output, 1: one-cycle completion pulse.
- `err`, output, 1: one-cycle pulse coincident with `done` on a rejected request.
- `mem_address`, output, ADDR_W: to memory `address`.
- `mem_write_data`, output, DATA_W: to memory `writeData`.
- `mem_write`, output, 1: to memory `MemWrite`.
- `mem_read`, output, 1: to memory `MemRead`.
- `mem_read_data`, input, DATA_W: from memory `readData`.

## Operation
- States:
  - IDLE: all outputs 0.
  - CHECK: one cycle.
  - READ and WRITE: alternate, one cycle each per byte.
  - DONE: one cycle.
- Start capture: `start`=1 in IDLE latches `src_addr`, `dst_addr` and `length`, then moves to CHECK. Input changes after capture have no effect.
- CHECK, reject case: if src+length > MEM_DEPTH or dst+length > MEM_DEPTH, go to DONE with `err`=1. No memory access is made. Sums are computed 9 bits wide, with no wrap.
- CHECK, zero length: length=0 goes to DONE with `err`=0.
- CHECK, direction: descending when dst > src and dst < src+length; ascending otherwise.
- Index: `idx` starts at 0 (ascending) or length-1 (descending).
- READ:
  - Drive `mem_read`=1 and `mem_address`=src+idx.
  - Capture `mem_read_data` into hold register `hold` at the edge.
- WRITE:
  - Drive `mem_write`=1, `mem_address`=dst+idx and `mem_write_data`=hold.
  - Step `idx` by ±1 and decrement the remaining count.
  - Go to DONE when remaining reaches 0, else back to READ.
- Strobe rules:
  - `mem_read` and `mem_write` are never both high.
  - `mem_write_data`=0 except in WRITE.
  - `mem_address`=0 in IDLE, CHECK and DONE.
- DONE: `done`=1, then IDLE. `start` seen in DONE is ignored.
- `start` is ignored in every state except IDLE.
- src==dst with length>0: performs a full copy, so data is unchanged.
- Reset mid-transfer:
  - Outputs go low immediately (async) and state returns to IDLE.
  - Already-written bytes remain in memory; there is no `done` pulse.

## Timing
- Reset value of every output is 0; `hold`, `idx` and the latched operands are also 0.
- Cycle numbering: start sampled at edge E0. CHECK is the cycle after E0. First READ is the cycle after E1.
- Byte k occupies READ at cycle 2k+2 and WRITE at cycle 2k+3.
- `done` is high in cycle 2·length+2 after E0; `busy` drops in that same cycle.
- For rejected or zero-length requests, `done` (and `err` if rejected) is high in cycle 2.
- The next `start` is accepted at the edge ending the first IDLE cycle after DONE.
- All outputs are registered-state decodes with no combinational path from `mem_read_data`.

## Configuration
- `COPY_CHECKSUM_EN` defined:
  - Adds output `checksum` [DATA_W-1:0], the mod-2^DATA_W sum of all bytes read.
  - Cleared at start capture and valid while `done`=1; holds its value until the next start.
  - Equals 0 for err or length=0.
- Undefined: no port and no adder.

## Structure
- Shared package `mem_copy_pkg`:
  - state encoding (IDLE=0, CHECK=1, READ=2, WRITE=3, DONE=4);
  - `MEM_DEPTH` and `LEN_W`=6 constants.
- One sub-module, `copy_addr_gen`: holds `idx` and the remaining count, steps them up or down, and outputs src+idx and dst+idx.
- FSM and strobe decode stay in the top module.

## Test plan
- Memory preloaded 0..15 and then −0..−15. Copy src=0, dst=20, len=4 -> mem[20..23]=0,1,2,3. `done` at cycle 10; 4 read/write pairs observed.
- Overlap: src=2, dst=4, len=4 over 0..15 -> mem[4..7]=2,3,4,5. Write addresses run 7,6,5,4.
- Bounds: src=30, dst=0, len=4 -> `err`=`done`=1 at cycle 2 with zero strobes. Same result for dst=29, len=4.
- len=0 -> `done` at cycle 2, `err`=0, no strobes. `start` pulsed during busy on another transfer -> ignored, only one `done`.
- Reset (low) asserted in the WRITE of byte 2 of a 6-byte copy -> strobes drop the same cycle. Bytes 0–1 are written and byte 2 onward is untouched. A new start then runs cleanly.
- `COPY_CHECKSUM_EN`: copy src=1, dst=16, len=5 -> checksum=15 (0x0F) with `done`.
